// File: rtl/count_seq_ctrl.sv
// Start/stop controlled up-counter with one-shot and periodic modes.
// Optional tick prescaler enabled by defining COUNT_SEQ_CTRL_PRESCALE_EN.
module count_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
    input  logic [1:0]       prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ack,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             tick_c;

`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
    localparam int unsigned PS_W = 2;
    logic [PS_W-1:0] psc_q, psc_d;
    logic [PS_W-1:0] div_q, div_d;

    // A tick fires once the divider has counted through the latched prescale.
    assign tick_c = (div_q == psc_q);
`else
    assign tick_c = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
        psc_d   = psc_q;
        div_d   = div_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    limit_d = limit;
                    mode_d  = mode;
                    ack_d   = 1'b1;
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
                    psc_d   = prescale;
                    div_d   = '0;
`endif
                end
            end
            S_RUN: begin
                // stop outranks both increment and terminal detection
                if (stop) begin
                    state_d = S_HOLD;
                end else begin
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
                    div_d = tick_c ? '0 : PS_W'(div_q + 1'b1);
`endif
                    if (tick_c) begin
                        if (count_q == limit_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = WIDTH'(count_q + 1'b1);
                        end
                    end
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = S_RUN;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
            psc_q   <= '0;
            div_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
            psc_q   <= psc_d;
            div_q   <= div_d;
`endif
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign ack   = ack_q;
    assign done  = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized self-checking bench for count_seq_ctrl against a behavioural model.
module tb_count_seq_ctrl;

    localparam int unsigned WIDTH = 4;
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, mode;
    logic [WIDTH-1:0] limit;
    logic [1:0]       ps;
    logic [WIDTH-1:0] count;
    logic             busy, ack, done;

    int total = 0;
    int bad   = 0;

    // model: phase 0=idle 1=run 2=hold 3=done
    int m_ph, m_cnt, m_lim, m_md, m_psc, m_sub;
    int m_ack, m_done;

    always #5 clk = ~clk;

    count_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .limit   (limit),
`ifdef COUNT_SEQ_CTRL_PRESCALE_EN
        .prescale(ps),
`endif
        .count   (count),
        .busy    (busy),
        .ack     (ack),
        .done    (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_lim = 0; m_md = 0; m_psc = 0; m_sub = 0;
        m_ack = 0; m_done = 0;
    endtask

    // Behaviour per clock edge: elapsed run cycles since last tick in m_sub.
    task automatic model_edge();
        m_ack = 0;
        m_done = 0;
        if (m_ph == 0 || m_ph == 3) begin
            if (start) begin
                m_ph = 1; m_cnt = 0; m_lim = int'(limit); m_md = int'(mode);
                m_psc = PS_EN ? int'(ps) : 0; m_sub = 0; m_ack = 1;
            end
        end else if (m_ph == 1) begin
            if (stop) begin
                m_ph = 2;
            end else if (m_sub < m_psc) begin
                m_sub++;
            end else begin
                m_sub = 0;
                if (m_cnt == m_lim) begin
                    m_done = 1;
                    if (m_md == 1) m_cnt = 0;
                    else m_ph = 3;
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            if (stop) begin
                m_ph = 0; m_cnt = 0;
            end else if (start) begin
                m_ph = 1; m_ack = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_count"}, int'(count), m_cnt);
        check_eq({tag, "_busy"}, int'(busy), (m_ph == 1 || m_ph == 2) ? 1 : 0);
        check_eq({tag, "_ack"}, int'(ack), m_ack);
        check_eq({tag, "_done"}, int'(done), m_done);
    endtask

    task automatic step(input string tag, input logic s, input logic p, input logic m,
                        input logic [WIDTH-1:0] l, input logic [1:0] pv);
        start = s; stop = p; mode = m; limit = l; ps = pv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0; ps = '0;
        model_reset();
        #3;
        check_all("rst");
        #10;
        reset = 1'b0;

        // one-shot limit 3
        step("os_acc", 1'b1, 1'b0, 1'b0, 4'd3, 2'd0);
        check_eq("os_ack", int'(ack), 1);
        for (int i = 0; i < 4; i++) step("os_run", 1'b0, 1'b0, 1'b1, 4'd7, 2'd0);
        check_eq("os_end_cnt", int'(count), 3);
        check_eq("os_end_busy", int'(busy), 0);
        check_eq("os_end_done", int'(done), 1);
        step("os_idle", 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        check_eq("os_hold3", int'(count), 3);

        // periodic limit 2
        step("per_acc", 1'b1, 1'b0, 1'b1, 4'd2, 2'd0);
        for (int i = 0; i < 6; i++) step("per_run", 1'b0, 1'b0, 1'b0, 4'd9, 2'd0);
        check_eq("per_busy", int'(busy), 1);
        check_eq("per_cnt", int'(count), 0);
        check_eq("per_done", int'(done), 1);

        // stop and resume, then abort
        step("sr_acc", 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        step("sr_abort", 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        step("sr_new", 1'b1, 1'b0, 1'b0, 4'd9, 2'd0);
        for (int i = 0; i < 5; i++) step("sr_run", 1'b0, 1'b0, 1'b0, 4'd1, 2'd0);
        step("sr_stop", 1'b0, 1'b1, 1'b0, 4'd1, 2'd0);
        check_eq("sr_frozen", int'(count), 5);
        step("sr_hold", 1'b0, 1'b0, 1'b0, 4'd1, 2'd0);
        step("sr_resume", 1'b1, 1'b0, 1'b0, 4'd1, 2'd0);
        check_eq("sr_res_ack", int'(ack), 1);
        step("sr_inc", 1'b0, 1'b0, 1'b0, 4'd1, 2'd0);
        check_eq("sr_six", int'(count), 6);
        step("sr_stop2", 1'b0, 1'b1, 1'b0, 4'd1, 2'd0);
        step("sr_both", 1'b1, 1'b1, 1'b0, 4'd1, 2'd0);
        check_eq("sr_both_cnt", int'(count), 0);
        check_eq("sr_both_busy", int'(busy), 0);

        // limit 0 one-shot and periodic
        step("l0_os", 1'b1, 1'b0, 1'b0, 4'd0, 2'd0);
        step("l0_os_run", 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        check_eq("l0_os_done", int'(done), 1);
        step("l0_per", 1'b1, 1'b0, 1'b1, 4'd0, 2'd0);
        for (int i = 0; i < 4; i++) step("l0_per_run", 1'b0, 1'b0, 1'b0, 4'd5, 2'd0);
        check_eq("l0_per_done", int'(done), 1);
        step("l0_stop", 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
        step("l0_abort", 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);

        // full-range limit
        step("max_acc", 1'b1, 1'b0, 1'b0, 4'd15, 2'd0);
        for (int i = 0; i < 16; i++) step("max_run", 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        check_eq("max_cnt", int'(count), 15);
        check_eq("max_done", int'(done), 1);

        // asynchronous reset mid-run at count 7
        step("ar_acc", 1'b1, 1'b0, 1'b0, 4'd9, 2'd0);
        for (int i = 0; i < 7; i++) step("ar_run", 1'b0, 1'b0, 1'b0, 4'd9, 2'd0);
        check_eq("ar_pre", int'(count), 7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("ar_async");
        #1;
        reset = 1'b0;
        step("ar_after", 1'b1, 1'b0, 1'b0, 4'd2, 2'd0);
        check_eq("ar_after_ack", int'(ack), 1);

        if (PS_EN) begin
            step("ps_acc", 1'b1, 1'b0, 1'b0, 4'd9, 2'd2);
            for (int i = 0; i < 3; i++) step("ps_run", 1'b0, 1'b0, 1'b0, 4'd9, 2'd0);
            check_eq("ps_cnt1", int'(count), 1);
            for (int i = 0; i < 3; i++) step("ps_run", 1'b0, 1'b0, 1'b0, 4'd9, 2'd0);
            check_eq("ps_cnt2", int'(count), 2);
        end

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [WIDTH-1:0] l;
            l = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
            step("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom), l, 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
